core_scheduler: RTL
===================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4, number of processing cores sequenced and sharing the one data-memory port.
REQ-002 Parameter AW, default 8, data-memory address width.
REQ-003 Parameter DW, default 16, data-memory word width.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; in IDLE, a sampled 1 launches a job.
REQ-007 core_en  input  NUM_CORES  per-core enable mask, captured at launch.
REQ-008 core_end  input  NUM_CORES  per-core end_process flag, level.
REQ-009 core_req  input  NUM_CORES  per-core data-memory access request, held until granted.
REQ-010 core_we  input  NUM_CORES  per-core write flag, qualified by core_req.
REQ-011 core_addr  input  NUM_CORES*AW  packed per-core addresses; core n uses bits [n*AW +: AW].
REQ-012 core_wdata  input  NUM_CORES*DW  packed per-core write data; core n uses bits [n*DW +: DW].
REQ-013 core_gnt  output  NUM_CORES  one-hot grant; at most one bit set.
REQ-014 core_rvalid  output  NUM_CORES  one-hot read-data-valid.
REQ-015 core_rdata  output  DW  memory read data, broadcast to all cores.
REQ-016 core_status  output  NUM_CORES*2  packed per-core status (encoding in REQ-024).
REQ-017 mem_we  output  1  data-memory write enable.
REQ-018 mem_addr  output  AW  data-memory address.
REQ-019 mem_wdata  output  DW  data-memory write data.
REQ-020 mem_rdata  input  DW  data-memory read data, valid one cycle after the address is presented.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse on the cycle the FSM enters DONE.

Function
REQ-023 The FSM SHALL have the states IDLE, LAUNCH, RUN and DONE, with these transitions:
- IDLE->LAUNCH on start=1 with core_en nonzero.
- LAUNCH->RUN after exactly one cycle.
- RUN->DONE when every captured-enabled core has core_end=1.
- DONE->IDLE when start=0.
REQ-024 core_status encoding: 00 HOLD, 01 RUN, 10 WAIT, 11 FIN.
- Disabled cores SHALL show HOLD in every state.
- Enabled cores SHALL show RUN from LAUNCH onwards.
- An enabled core SHALL show WAIT while core_req=1 and it is not granted.
- An enabled core SHALL show FIN once its core_end=1; FIN is sticky until IDLE.
REQ-025 In IDLE with start=1 and core_en=0, the block SHALL stay in IDLE and SHALL NOT pulse done.
REQ-026 Arbitration SHALL be round-robin and SHALL run in RUN only.
- The priority pointer starts at core 0 at launch.
- Requests sampled in cycle t produce a registered one-hot core_gnt in cycle t+1.
- After a grant to core g, the pointer SHALL move to g+1 mod NUM_CORES.
REQ-027 A granted core SHALL NOT be granted in the following cycle; core_gnt SHALL be all-zero for at least one cycle after each grant.
- Worst-case grant latency: 2*NUM_CORES cycles.
REQ-028 While core_gnt has bit g set:
- mem_addr = core_addr[g].
- mem_wdata = core_wdata[g].
- mem_we = core_we[g].
REQ-029 With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 For a read grant (core_we=0) in cycle t, core_rvalid[g]=1 in cycle t+1, and core_rdata SHALL equal mem_rdata in that cycle.
REQ-031 Requests from disabled or FIN cores SHALL be ignored.
REQ-032 A grant in flight when the FSM leaves RUN SHALL complete, including its rvalid; no new grants SHALL be issued outside RUN.
REQ-033 core_en changes after LAUNCH SHALL have no effect until the next launch.

Reset
REQ-034 Asserting reset SHALL immediately force all of the following, including mid-operation, with no partial write completing after reset:
- FSM state IDLE, pointer 0.
- core_gnt=0, core_rvalid=0, core_status all HOLD.
- mem_we=0, mem_addr=0, mem_wdata=0.
- busy=0, done=0, FIN flags and captured enable mask cleared.

Structure
REQ-035 The FSM state encoding and the status codes SHALL be defined as constants in the shared package core_pkg.
REQ-036 The round-robin grant logic SHALL be a sub-module rr_arbiter, parameterised by NUM_CORES.

Verification
REQ-037 Launch: core_en=4'b0101, start=1 -> LAUNCH one cycle, then core_status = {HOLD,RUN,HOLD,RUN} (core3..core0), busy=1.
REQ-038 Fairness: all four cores hold core_req=1 -> grants in order 0,1,2,3,0, each followed by one idle cycle.
REQ-039 Read path: core 2 reads address 0x3C with the memory holding 0xBEEF -> core_gnt=0100, mem_addr=0x3C, mem_we=0; next cycle core_rvalid=0100, core_rdata=0xBEEF.
REQ-040 Write path: core 1 writes 0x1234 to 0x10 -> mem_we=1 for exactly one cycle; core 1 shows WAIT until granted.
REQ-041 Completion: enabled cores raise core_end at different cycles -> statuses go to FIN individually; done pulses once after the last core_end; IDLE is reached after start drops.
REQ-042 Reset mid-write: reset asserted during a grant cycle -> mem_we drops immediately, all outputs take their REQ-034 values, and no grant appears after reset is released until a new launch.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core scheduler: FSM states, per-core status codes
// and a pointer-width helper for the arbiter.
package core_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_RUN    = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  localparam logic [1:0] STAT_HOLD = 2'b00;
  localparam logic [1:0] STAT_RUN  = 2'b01;
  localparam logic [1:0] STAT_WAIT = 2'b10;
  localparam logic [1:0] STAT_FIN  = 2'b11;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant; every grant is
// followed by at least one idle cycle so the winner can drop its request.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt
);

  localparam int PW = ptr_width(NUM_CORES);

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_CORES);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt <= '0;
      ptr <= '0;
    end else if (clear) begin
      gnt <= '0;
      ptr <= '0;
    end else if (enable && (gnt == '0) && found) begin
      gnt <= NUM_CORES'(1) << pick;
      ptr <= (pick == PW'(NUM_CORES - 1)) ? '0 : pick + 1'b1;
    end else begin
      gnt <= '0;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Sequences a job across NUM_CORES cores and arbitrates their shared
// data-memory port; read data returns one cycle after the grant.
//
// state  | meaning
// IDLE   | waiting for start with a nonzero enable mask
// LAUNCH | enable mask captured, arbiter pointer reset
// RUN    | cores active, arbitration running
// DONE   | all enabled cores finished, waiting for start to drop
module core_scheduler
  import core_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int AW        = 8,
  parameter int DW        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CORES-1:0]    core_en,
  input  logic [NUM_CORES-1:0]    core_end,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  input  logic [NUM_CORES*DW-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_gnt,
  output logic [NUM_CORES-1:0]    core_rvalid,
  output logic [DW-1:0]           core_rdata,
  output logic [NUM_CORES*2-1:0]  core_status,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    busy,
  output logic                    done
);

  state_t               state;
  logic [NUM_CORES-1:0] en_cap;
  logic [NUM_CORES-1:0] fin;
  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] live_req;
  logic                 all_end;
  logic                 arb_en;

  assign all_end  = &(fin | core_end | ~en_cap);
  assign live_req = core_req & en_cap & ~fin;
  // Stop issuing on the exit cycle so no grant first appears in DONE.
  assign arb_en   = (state == S_RUN) && !all_end;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_en),
    .clear  (state == S_LAUNCH),
    .req    (live_req),
    .gnt    (gnt)
  );

  assign core_gnt   = gnt;
  assign core_rdata = mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      en_cap <= '0;
      fin    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          fin <= '0;
          if (start && (core_en != '0)) begin
            state  <= S_LAUNCH;
            en_cap <= core_en;
            busy   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          fin   <= fin | (core_end & en_cap);
          state <= S_RUN;
        end
        S_RUN: begin
          fin <= fin | (core_end & en_cap);
          if (all_end) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) core_rvalid <= '0;
    else       core_rvalid <= gnt & ~core_we;
  end

  always_comb begin
    core_status = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if ((state != S_IDLE) && en_cap[n]) begin
        if (fin[n])                      core_status[n*2 +: 2] = STAT_FIN;
        else if (core_req[n] && !gnt[n]) core_status[n*2 +: 2] = STAT_WAIT;
        else                             core_status[n*2 +: 2] = STAT_RUN;
      end else begin
        core_status[n*2 +: 2] = STAT_HOLD;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (gnt[n]) begin
        mem_we    = core_we[n];
        mem_addr  = core_addr[n*AW +: AW];
        mem_wdata = core_wdata[n*DW +: DW];
      end
    end
  end

endmodule
